// File: rtl/tcp_vlg_pkg.sv
// Shared TCP types for the vlg TCP stack, including the TX SACK scoreboard entry
// and the wrap-safe sequence-number comparison.
package tcp_vlg_pkg;

  typedef logic [31:0] tcp_num_t;

  typedef struct packed {
    tcp_num_t left;
    tcp_num_t right;
  } tcp_sack_block_t;

  typedef struct packed {
    tcp_sack_block_t [0:3] block;
    logic            [0:3] block_pres;
  } tcp_opt_sack_t;

  typedef struct packed {
    tcp_num_t left;
    tcp_num_t right;
    logic     sacked;
    logic     rtx;
  } tcp_tx_seg_t;

  localparam logic [2:0] IDLE_S = 3'd0;
  localparam logic [2:0] ACK_S  = 3'd1;
  localparam logic [2:0] SACK_S = 3'd2;
  localparam logic [2:0] SCAN_S = 3'd3;
  localparam logic [2:0] TO_S   = 3'd4;
  localparam logic [2:0] REQ_S  = 3'd5;

  // a <= b in modulo-2^32 sequence space.
  function automatic logic seq_le(input tcp_num_t a, input tcp_num_t b);
    tcp_num_t diff;
    diff = b - a;
    return !diff[31];
  endfunction

endpackage

// File: rtl/tcp_vlg_tx_sack_tmr.sv
// Retransmission-timeout counter: counts while running, saturates at TIMEOUT-1.
module tcp_vlg_tx_sack_tmr #(
  parameter int unsigned TIMEOUT = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !run_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/tcp_vlg_tx_sack.sv
// Transmit-side SACK scoreboard: tracks unacked segments, applies remote ACK/SACK,
// and requests retransmission of SACK holes and of the head entry on RTO.
module tcp_vlg_tx_sack
  import tcp_vlg_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned TIMEOUT = 1250,
  parameter bit          VERBOSE = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  tcp_num_t      init_ack,
  input  logic          add_val,
  output logic          add_rdy,
  input  tcp_num_t      add_start,
  input  tcp_num_t      add_stop,
  input  logic          ack_val,
  output logic          ack_rdy,
  input  tcp_num_t      ack_num,
  input  tcp_opt_sack_t ack_sack,
  output tcp_num_t      rem_ack,
  output logic          rtx_val,
  input  logic          rtx_rdy,
  output tcp_num_t      rtx_start,
  output tcp_num_t      rtx_stop,
  output logic          empty
);

  localparam int unsigned AW = $clog2(ENTRIES);

  tcp_tx_seg_t   tbl_q [ENTRIES];
  logic [AW:0]   wr_q, rd_q, idx_q, idx_d;
  logic [AW-1:0] cand_q, cand_d;
  logic          cand_v_q, cand_v_d;
  logic [2:0]    fsm_q, fsm_d;
  tcp_num_t      rem_ack_q, rem_ack_d, ack_q;
  tcp_num_t      rtx_start_q, rtx_start_d, rtx_stop_q, rtx_stop_d;
  tcp_opt_sack_t sack_q;

  logic        full, empty_w, push, pop, covered, idx_end;
  logic        set_sacked, set_rtx, clr_rtx, tmr_clr, expired;
  tcp_tx_seg_t head, cur;

  assign empty_w = (wr_q == rd_q);
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign push    = add_val && !full;
  assign head    = tbl_q[rd_q[AW-1:0]];
  assign cur     = tbl_q[idx_q[AW-1:0]];
  assign idx_end = (idx_q == wr_q);
  assign pop     = (fsm_q == ACK_S) && !empty_w && seq_le(head.right, ack_q);

  always_comb begin
    covered = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sack_q.block_pres[i] && seq_le(sack_q.block[i].left, cur.left) &&
          seq_le(cur.right, sack_q.block[i].right)) begin
        covered = 1'b1;
      end
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    cand_d      = cand_q;
    cand_v_d    = cand_v_q;
    rem_ack_d   = rem_ack_q;
    rtx_start_d = rtx_start_q;
    rtx_stop_d  = rtx_stop_q;
    set_sacked  = 1'b0;
    set_rtx     = 1'b0;
    clr_rtx     = 1'b0;
    tmr_clr     = 1'b0;
    case (fsm_q)
      IDLE_S: begin
        if (ack_val) fsm_d = ACK_S;
        else if (expired && !empty_w) fsm_d = TO_S;
      end
      ACK_S: begin
        if (!pop) begin
          fsm_d = SACK_S;
          idx_d = rd_q;
          if (!seq_le(ack_q, rem_ack_q)) rem_ack_d = ack_q;
        end
      end
      SACK_S: begin
        if (idx_end) begin
          fsm_d    = SCAN_S;
          idx_d    = rd_q;
          cand_v_d = 1'b0;
        end else begin
          set_sacked = covered;
          idx_d      = idx_q + 1'b1;
        end
      end
      SCAN_S: begin
        // First un-sacked, un-retransmitted entry is the hole once any later entry is sacked.
        if (idx_end) begin
          fsm_d = IDLE_S;
        end else if (cand_v_q && cur.sacked) begin
          fsm_d       = REQ_S;
          rtx_start_d = tbl_q[cand_q].left;
          rtx_stop_d  = tbl_q[cand_q].right;
          set_rtx     = 1'b1;
        end else begin
          if (!cand_v_q && !cur.sacked && !cur.rtx) begin
            cand_v_d = 1'b1;
            cand_d   = idx_q[AW-1:0];
          end
          idx_d = idx_q + 1'b1;
        end
      end
      TO_S: begin
        fsm_d       = REQ_S;
        rtx_start_d = head.left;
        rtx_stop_d  = head.right;
        clr_rtx     = 1'b1;
        tmr_clr     = 1'b1;
      end
      REQ_S: begin
        if (rtx_rdy) fsm_d = IDLE_S;
      end
      default: fsm_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
    end else if (init) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
    end else begin
      if (clr_rtx) begin
        for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i].rtx <= 1'b0;
      end
      if (set_sacked) tbl_q[idx_q[AW-1:0]].sacked <= 1'b1;
      if (set_rtx) tbl_q[cand_q].rtx <= 1'b1;
      if (push) tbl_q[wr_q[AW-1:0]] <= '{left: add_start, right: add_stop, sacked: 1'b0, rtx: 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || init) begin
      fsm_q       <= IDLE_S;
      wr_q        <= '0;
      rd_q        <= '0;
      idx_q       <= '0;
      cand_q      <= '0;
      cand_v_q    <= 1'b0;
      rem_ack_q   <= rst ? '0 : init_ack;
      ack_q       <= '0;
      sack_q      <= '0;
      rtx_start_q <= '0;
      rtx_stop_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      cand_q      <= cand_d;
      cand_v_q    <= cand_v_d;
      rem_ack_q   <= rem_ack_d;
      rtx_start_q <= rtx_start_d;
      rtx_stop_q  <= rtx_stop_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (fsm_q == IDLE_S && ack_val) begin
        ack_q  <= ack_num;
        sack_q <= ack_sack;
      end
    end
  end

  tcp_vlg_tx_sack_tmr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (init || pop || tmr_clr),
    .run_i     (!empty_w),
    .expired_o (expired)
  );

  assign add_rdy   = !full;
  assign ack_rdy   = (fsm_q == IDLE_S);
  assign rtx_val   = (fsm_q == REQ_S);
  assign rtx_start = rtx_start_q;
  assign rtx_stop  = rtx_stop_q;
  assign rem_ack   = rem_ack_q;
  assign empty     = empty_w;

endmodule

// File: tb/tb_tcp_vlg_tx_sack.sv
// Self-checking bench for tcp_vlg_tx_sack: directed scenarios plus randomized
// ACK/SACK traffic checked against a queue-based scoreboard model.
module tb_tcp_vlg_tx_sack;
  import tcp_vlg_pkg::*;

  localparam int unsigned ENT = 8;
  localparam int unsigned TO  = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init = 1'b0;
  tcp_num_t      init_ack = '0;
  logic          add_val = 1'b0;
  logic          add_rdy;
  tcp_num_t      add_start = '0;
  tcp_num_t      add_stop = '0;
  logic          ack_val = 1'b0;
  logic          ack_rdy;
  tcp_num_t      ack_num = '0;
  tcp_opt_sack_t ack_sack = '0;
  tcp_num_t      rem_ack;
  logic          rtx_val;
  logic          rtx_rdy = 1'b0;
  tcp_num_t      rtx_start, rtx_stop;
  logic          empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    tcp_num_t l;
    tcp_num_t r;
    bit       sk;
    bit       rx;
  } mseg_t;

  mseg_t    mq[$];
  tcp_num_t m_rem;

  tcp_vlg_tx_sack #(.ENTRIES(ENT), .TIMEOUT(TO), .VERBOSE(1'b0)) dut (
    .clk(clk), .rst(rst), .init(init), .init_ack(init_ack),
    .add_val(add_val), .add_rdy(add_rdy), .add_start(add_start), .add_stop(add_stop),
    .ack_val(ack_val), .ack_rdy(ack_rdy), .ack_num(ack_num), .ack_sack(ack_sack),
    .rem_ack(rem_ack), .rtx_val(rtx_val), .rtx_rdy(rtx_rdy),
    .rtx_start(rtx_start), .rtx_stop(rtx_stop), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic bit m_le(input tcp_num_t a, input tcp_num_t b);
    tcp_num_t d;
    d = b - a;
    return d < 32'h8000_0000;
  endfunction

  // Scoreboard: cumulative pops, SACK marking, then oldest eligible hole.
  task automatic m_ack(input tcp_num_t num, input tcp_opt_sack_t s,
                       output bit exp, output tcp_num_t es, output tcp_num_t ee);
    int hole;
    exp = 0; es = '0; ee = '0; hole = -1;
    while (mq.size() > 0 && m_le(mq[0].r, num)) void'(mq.pop_front());
    if (!m_le(num, m_rem)) m_rem = num;
    foreach (mq[e])
      for (int b = 0; b < 4; b++)
        if (s.block_pres[b] && m_le(s.block[b].left, mq[e].l) && m_le(mq[e].r, s.block[b].right))
          mq[e].sk = 1;
    foreach (mq[e]) if (hole < 0 && !mq[e].sk && !mq[e].rx) hole = e;
    if (hole >= 0)
      for (int e = hole + 1; e < mq.size(); e++) if (mq[e].sk) exp = 1;
    if (exp) begin
      mq[hole].rx = 1; es = mq[hole].l; ee = mq[hole].r;
    end
  endtask

  task automatic do_init(input tcp_num_t base);
    @(negedge clk); init = 1; init_ack = base;
    @(negedge clk); init = 0;
    mq.delete(); m_rem = base;
  endtask

  task automatic push_seg(input tcp_num_t s, input tcp_num_t e);
    add_val = 1; add_start = s; add_stop = e;
    @(negedge clk); add_val = 0;
    if (mq.size() < ENT) mq.push_back('{l: s, r: e, sk: 1'b0, rx: 1'b0});
  endtask

  task automatic do_ack(input tcp_num_t num, input tcp_opt_sack_t s,
                        output int nrtx, output tcp_num_t gs, output tcp_num_t ge);
    bit done;
    done = 0; nrtx = 0; gs = '0; ge = '0;
    ack_val = 1; ack_num = num; ack_sack = s;
    @(negedge clk); ack_val = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (rtx_val) begin
        if (nrtx == 0) begin gs = rtx_start; ge = rtx_stop; end
        nrtx++; rtx_rdy = 1;
      end else begin
        rtx_rdy = 0;
        if (ack_rdy) done = 1;
      end
      if (!done) @(negedge clk);
    end
    rtx_rdy = 0;
    checks++;
    if (!done) begin errors++; $display("FAIL ack_done: ack_rdy=%b required 1", ack_rdy); end
  endtask

  task automatic test_reset();
    rst = 1; repeat (2) @(negedge clk);
    rst = 0; @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b exp 1", empty); end
    checks++; if (add_rdy !== 1'b1) begin errors++; $display("FAIL rst_add_rdy: got %b exp 1", add_rdy); end
    checks++; if (ack_rdy !== 1'b1) begin errors++; $display("FAIL rst_ack_rdy: got %b exp 1", ack_rdy); end
    checks++; if (rtx_val !== 1'b0) begin errors++; $display("FAIL rst_rtx_val: got %b exp 0", rtx_val); end
    checks++; if (rem_ack !== 32'h0) begin errors++; $display("FAIL rst_rem_ack: got %h exp 0", rem_ack); end
    do_init(32'h1234_5678);
    checks++; if (rem_ack !== 32'h1234_5678) begin errors++; $display("FAIL init_rem_ack: got %h exp 12345678", rem_ack); end
  endtask

  task automatic test_cum_ack();
    int n; tcp_num_t gs, ge;
    do_init(1000);
    push_seg(1000, 1100); push_seg(1100, 1200); push_seg(1200, 1300);
    do_ack(1200, '0, n, gs, ge);
    checks++; if (rem_ack !== 32'd1200) begin errors++; $display("FAIL cum_rem_ack: got %0d exp 1200", rem_ack); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL cum_empty: got %b exp 0", empty); end
    checks++; if (n !== 0) begin errors++; $display("FAIL cum_no_rtx: got %0d exp 0", n); end
    do_ack(1300, '0, n, gs, ge);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL cum_last_pop: got %b exp 1", empty); end
  endtask

  task automatic test_sack_hole();
    int n; tcp_num_t gs, ge; tcp_opt_sack_t s;
    do_init(1000);
    for (int k = 0; k < 4; k++) push_seg(1000 + 100 * k, 1100 + 100 * k);
    s = '0; s.block_pres[0] = 1'b1; s.block[0].left = 1100; s.block[0].right = 1300;
    do_ack(1000, s, n, gs, ge);
    checks++; if (n !== 1) begin errors++; $display("FAIL sack_rtx_cnt: got %0d exp 1", n); end
    checks++; if (gs !== 32'd1000 || ge !== 32'd1100) begin errors++; $display("FAIL sack_rtx_range: got %0d..%0d exp 1000..1100", gs, ge); end
    checks++; if (rem_ack !== 32'd1000) begin errors++; $display("FAIL sack_rem_ack: got %0d exp 1000", rem_ack); end
    do_ack(1000, s, n, gs, ge);
    checks++; if (n !== 0) begin errors++; $display("FAIL sack_repeat: got %0d requests exp 0", n); end
  endtask

  task automatic test_timeout();
    int c; bit found; tcp_num_t hs, he;
    do_init(5000);
    push_seg(5000, 5100);
    c = 1; found = 0;
    for (int i = 0; i < TO + 20 && !found; i++) begin
      if (rtx_val) found = 1; else begin @(negedge clk); c++; end
    end
    checks++; if (!found || c < TO - 2 || c > TO + 2) begin errors++; $display("FAIL to_latency: got %0d cycles (seen %b) exp %0d+-2", c, found, TO); end
    checks++; if (rtx_start !== 32'd5000 || rtx_stop !== 32'd5100) begin errors++; $display("FAIL to_range: got %0d..%0d exp 5000..5100", rtx_start, rtx_stop); end
    hs = rtx_start; he = rtx_stop;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rtx_val !== 1'b1 || rtx_start !== hs || rtx_stop !== he) begin errors++; $display("FAIL to_hold: val=%b %0d..%0d exp 1 %0d..%0d", rtx_val, rtx_start, rtx_stop, hs, he); end
    end
    rtx_rdy = 1; @(negedge clk); rtx_rdy = 0;
    checks++; if (rtx_val !== 1'b0) begin errors++; $display("FAIL to_release: got %b exp 0", rtx_val); end
    found = 0;
    for (int i = 0; i < 2 * TO && !found; i++) begin
      if (rtx_val) found = 1; else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL to_repeat: rtx_val=%b exp 1", rtx_val); end
    init = 1; init_ack = 7000; @(negedge clk); init = 0;
    checks++; if (rtx_val !== 1'b0 || empty !== 1'b1 || rem_ack !== 32'd7000) begin errors++; $display("FAIL init_abort: val=%b empty=%b rem=%0d exp 0 1 7000", rtx_val, empty, rem_ack); end
    mq.delete(); m_rem = 7000;
  endtask

  task automatic test_wrap();
    int n; tcp_num_t gs, ge;
    do_init(32'hFFFF_FFC0);
    push_seg(32'hFFFF_FFC0, 32'h0000_0040);
    do_ack(32'h0000_0040, '0, n, gs, ge);
    checks++; if (rem_ack !== 32'h0000_0040) begin errors++; $display("FAIL wrap_rem_ack: got %h exp 00000040", rem_ack); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b exp 1", empty); end
  endtask

  task automatic test_full();
    int n; tcp_num_t gs, ge;
    do_init(32'h100);
    for (int k = 0; k < ENT; k++) push_seg(32'h100 + 100 * k, 32'h100 + 100 * (k + 1));
    checks++; if (add_rdy !== 1'b0) begin errors++; $display("FAIL full_add_rdy: got %b exp 0", add_rdy); end
    add_val = 1; add_start = 32'h9000; add_stop = 32'h9100; @(negedge clk); add_val = 0;
    checks++; if (add_rdy !== 1'b0) begin errors++; $display("FAIL full_drop: add_rdy got %b exp 0", add_rdy); end
    do_ack(32'h100 + 100 * (ENT - 1), '0, n, gs, ge);
    checks++; if (empty !== 1'b0 || add_rdy !== 1'b1) begin errors++; $display("FAIL full_partial: empty=%b add_rdy=%b exp 0 1", empty, add_rdy); end
    do_ack(32'h100 + 100 * ENT, '0, n, gs, ge);
    checks++; if (empty !== 1'b1 || add_rdy !== 1'b1) begin errors++; $display("FAIL full_drain: empty=%b add_rdy=%b exp 1 1", empty, add_rdy); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      tcp_num_t base, p, num, gs, ge, es, ee;
      tcp_num_t sl[ENT];
      tcp_num_t sr[ENT];
      tcp_opt_sack_t s;
      int n, k, nr, bi, bj;
      bit exp;
      base = (it % 3 == 0) ? 32'hFFFF_FF80 + $urandom_range(0, 64) : $urandom;
      do_init(base);
      p = base;
      n = int'($urandom_range(1, ENT));
      for (int q = 0; q < n; q++) begin
        sl[q] = p; p = p + $urandom_range(1, 200); sr[q] = p;
        push_seg(sl[q], sr[q]);
      end
      checks++; if (add_rdy !== (n < ENT)) begin errors++; $display("FAIL rnd_add_rdy it%0d: got %b exp %b", it, add_rdy, n < ENT); end
      for (int a = 0; a < 2; a++) begin
        k = int'($urandom_range(0, n));
        num = (k == 0) ? base - $urandom_range(0, 40) : sr[k-1] - (($urandom_range(0, 3) == 0) ? 1 : 0);
        s = '0;
        for (int b = 0; b < 4; b++) begin
          bi = int'($urandom_range(0, n - 1));
          bj = int'($urandom_range(bi, n - 1));
          s.block_pres[b] = 1'($urandom_range(0, 1));
          s.block[b].left = sl[bi] + (($urandom_range(0, 4) == 0) ? 1 : 0);
          s.block[b].right = sr[bj];
        end
        m_ack(num, s, exp, es, ee);
        do_ack(num, s, nr, gs, ge);
        checks++; if (nr !== (exp ? 1 : 0)) begin errors++; $display("FAIL rnd_rtx_cnt it%0d.%0d: got %0d exp %0d", it, a, nr, exp); end
        if (exp) begin
          checks++; if (gs !== es || ge !== ee) begin errors++; $display("FAIL rnd_rtx_range it%0d.%0d: got %h..%h exp %h..%h", it, a, gs, ge, es, ee); end
        end
        checks++; if (rem_ack !== m_rem) begin errors++; $display("FAIL rnd_rem_ack it%0d.%0d: got %h exp %h", it, a, rem_ack, m_rem); end
        checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty it%0d.%0d: got %b exp %b", it, a, empty, mq.size() == 0); end
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_init(9000);
    push_seg(9000, 9100);
    found = 0;
    for (int i = 0; i < 2 * TO && !found; i++) begin
      if (rtx_val) found = 1; else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL arst_reach_req: rtx_val=%b exp 1", rtx_val); end
    #2 rst = 1;
    #1;
    checks++; if (rtx_val !== 1'b0 || empty !== 1'b1 || rem_ack !== 32'h0 || ack_rdy !== 1'b1) begin errors++; $display("FAIL arst_values: val=%b empty=%b rem=%h rdy=%b exp 0 1 0 1", rtx_val, empty, rem_ack, ack_rdy); end
    @(negedge clk); rst = 0;
  endtask

  initial begin
    test_reset();
    test_cum_ack();
    test_sack_hole();
    test_timeout();
    test_wrap();
    test_full();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
